// File: rtl/regfile_mp.sv
// Multi-port register file with two prioritised write ports and a per-register busy scoreboard.
// Reads are combinational. Optional write-to-read forwarding and an optional hardwired-zero R0.
module regfile_mp #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 8,
  parameter int NUM_READ   = 2,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we0,
  input  logic [AW-1:0]                  waddr0,
  input  logic [DATA_WIDTH-1:0]          wdata0,
  input  logic                           we1,
  input  logic [AW-1:0]                  waddr1,
  input  logic [DATA_WIDTH-1:0]          wdata1,
  input  logic [NUM_READ*AW-1:0]         raddr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rdata,
  output logic [NUM_READ-1:0]            rbusy,
  input  logic                           bset,
  input  logic [AW-1:0]                  bset_addr,
  output logic [NUM_REGS-1:0]            busy_vec,
  output logic                           wcollide
);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic we0_eff, we1_eff, bset_eff, collide;

  // Writes and sets aimed at a hardwired R0 are dropped before anything else sees them.
  assign we0_eff  = we0  && !(ZERO_REG && (waddr0 == '0));
  assign we1_eff  = we1  && !(ZERO_REG && (waddr1 == '0));
  assign bset_eff = bset && !(ZERO_REG && (bset_addr == '0));
  assign collide  = we0_eff && we1_eff && (waddr0 == waddr1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
      busy_vec <= '0;
      wcollide <= 1'b0;
    end else begin
      if (we0_eff) mem[waddr0] <= wdata0;
      if (we1_eff) mem[waddr1] <= wdata1;
      wcollide <= collide;
      // A set and a clearing writeback on the same register leave it busy.
      for (int r = 0; r < NUM_REGS; r++) begin
        if (bset_eff && (bset_addr == AW'(r)))
          busy_vec[r] <= 1'b1;
        else if ((we0_eff && (waddr0 == AW'(r))) || (we1_eff && (waddr1 == AW'(r))))
          busy_vec[r] <= 1'b0;
      end
    end
  end

  logic [AW-1:0]         ra;
  logic [DATA_WIDTH-1:0] rd;
  logic                  rb;
  logic                  hit;

  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    rd    = '0;
    rb    = 1'b0;
    hit   = 1'b0;
    for (int i = 0; i < NUM_READ; i++) begin
      ra  = raddr[i*AW +: AW];
      rd  = mem[ra];
      rb  = busy_vec[ra];
      hit = 1'b0;
      // Forwarding is held off during reset so reads stay at zero while rst_n is low.
      if (BYPASS && rst_n) begin
        if (we1_eff && (waddr1 == ra)) begin
          rd  = wdata1;
          hit = 1'b1;
        end else if (we0_eff && (waddr0 == ra)) begin
          rd  = wdata0;
          hit = 1'b1;
        end
        if (hit && !(bset_eff && (bset_addr == ra))) rb = 1'b0;
      end
      if (ZERO_REG && (ra == '0)) begin
        rd = '0;
        rb = 1'b0;
      end
      rdata[i*DATA_WIDTH +: DATA_WIDTH] = rd;
      rbusy[i] = rb;
    end
  end

endmodule
